// File: rtl/div_arb_pkg.sv
// Shared definitions for the divider-sharing arbiter.
//   state_t : arbiter FSM states (3-bit encoding)
//   DATA_W  : operand/result width (IEEE-754 double)
//   QNAN    : canonical quiet NaN pattern
//   PINF    : positive infinity pattern
package div_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRANT  = 3'd1,
        S_SEND_A = 3'd2,
        S_SEND_B = 3'd3,
        S_WAIT_Z = 3'd4,
        S_RETURN = 3'd5
    } state_t;

    localparam int          DATA_W = 64;
    localparam logic [63:0] QNAN   = 64'hFFF8000000000000;
    localparam logic [63:0] PINF   = 64'h7FF0000000000000;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req  : request vector, one bit per requester
//   last : index of the previously granted requester
//   any  : at least one request is pending
//   idx  : winner; the search starts at (last+1) mod NUM_REQ and wraps,
//          so the previous winner has the lowest priority
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               any,
    output logic [ID_W-1:0]    idx
);

    always_comb begin
        logic [ID_W-1:0] w_pos;
        any   = |req;
        idx   = last;
        w_pos = last;
        // Walk from the farthest candidate to the nearest one so the
        // nearest pending requester after 'last' is the final assignment.
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_pos = ID_W'((int'(last) + k) % NUM_REQ);
            if (req[w_pos]) begin
                idx = w_pos;
            end
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one unpipelined double-precision divider (stb/ack handshakes on
// a, b and z) between NUM_REQ requesters, granting in round-robin order.
// Exactly one operation is in flight; all outputs are registered.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   req_a/req_b            : packed operands, requester i at [i*DATA_W +: DATA_W]
//   req_stb / req_ack      : request valid / one-cycle one-hot accept pulse
//   rsp_z                  : quotient for the granted requester
//   rsp_stb / rsp_ack      : one-hot result valid (held) / per-requester accept
//   div_a*, div_b*, div_z* : handshakes toward the divider core
//   busy                   : high in every state except IDLE
//   grant_id               : current or last granted requester
//   ops_done               : completed-operation count (wraps)
// Handshake rule on every interface: a transfer happens on a rising clock
// edge where stb and ack are both high.
module div_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_stb,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [DATA_W-1:0]         rsp_z,
    output logic [NUM_REQ-1:0]        rsp_stb,
    input  logic [NUM_REQ-1:0]        rsp_ack,
    output logic [DATA_W-1:0]         div_a,
    output logic                      div_a_stb,
    input  logic                      div_a_ack,
    output logic [DATA_W-1:0]         div_b,
    output logic                      div_b_stb,
    input  logic                      div_b_ack,
    input  logic [DATA_W-1:0]         div_z,
    input  logic                      div_z_stb,
    output logic                      div_z_ack,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic [31:0]               ops_done
);

    import div_arb_pkg::*;

    localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);
    localparam logic [ID_W-1:0]    LAST_RST = ID_W'(NUM_REQ - 1);

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_req_ack;
    logic [NUM_REQ-1:0]  r_rsp_stb;
    logic [DATA_W-1:0]   r_rsp_z;
    logic [DATA_W-1:0]   r_div_a;
    logic [DATA_W-1:0]   r_div_b;
    logic                r_div_a_stb;
    logic                r_div_b_stb;
    logic                r_div_z_ack;
    logic                r_busy;
    logic [ID_W-1:0]     r_grant_id;
    logic [31:0]         r_ops_done;

    logic                w_any;
    logic [ID_W-1:0]     w_idx;
    logic [NUM_REQ-1:0]  w_pick_onehot;
    logic [NUM_REQ-1:0]  w_grant_onehot;
    logic [DATA_W-1:0]   w_sel_a;
    logic [DATA_W-1:0]   w_sel_b;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req  (req_stb),
        .last (r_grant_id),
        .any  (w_any),
        .idx  (w_idx)
    );

    assign w_pick_onehot  = ONE << w_idx;
    assign w_grant_onehot = ONE << r_grant_id;

    // Operand mux for the granted requester.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == ID_W'(i)) begin
                w_sel_a = req_a[i*DATA_W +: DATA_W];
                w_sel_b = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req_ack   <= '0;
            r_rsp_stb   <= '0;
            r_rsp_z     <= '0;
            r_div_a     <= '0;
            r_div_b     <= '0;
            r_div_a_stb <= 1'b0;
            r_div_b_stb <= 1'b0;
            r_div_z_ack <= 1'b0;
            r_busy      <= 1'b0;
            r_grant_id  <= LAST_RST;
            r_ops_done  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant_id <= w_idx;
                        // Raised here so the pulse occupies exactly the GRANT cycle.
                        r_req_ack  <= w_pick_onehot;
                        r_busy     <= 1'b1;
                        r_state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_req_ack   <= '0;
                    r_div_a     <= w_sel_a;
                    r_div_b     <= w_sel_b;
                    r_div_a_stb <= 1'b1;
                    r_state     <= S_SEND_A;
                end
                S_SEND_A: begin
                    if (r_div_a_stb && div_a_ack) begin
                        r_div_a_stb <= 1'b0;
                        r_div_b_stb <= 1'b1;
                        r_state     <= S_SEND_B;
                    end
                end
                S_SEND_B: begin
                    if (r_div_b_stb && div_b_ack) begin
                        r_div_b_stb <= 1'b0;
                        r_div_z_ack <= 1'b1;
                        r_state     <= S_WAIT_Z;
                    end
                end
                S_WAIT_Z: begin
                    if (div_z_stb && r_div_z_ack) begin
                        r_rsp_z     <= div_z;
                        r_div_z_ack <= 1'b0;
                        r_rsp_stb   <= w_grant_onehot;
                        r_state     <= S_RETURN;
                    end
                end
                S_RETURN: begin
                    // Only the granted requester's accept bit matters.
                    if (rsp_ack[r_grant_id]) begin
                        r_rsp_stb  <= '0;
                        r_ops_done <= r_ops_done + 32'd1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ack   = r_req_ack;
    assign rsp_stb   = r_rsp_stb;
    assign rsp_z     = r_rsp_z;
    assign div_a     = r_div_a;
    assign div_b     = r_div_b;
    assign div_a_stb = r_div_a_stb;
    assign div_b_stb = r_div_b_stb;
    assign div_z_ack = r_div_z_ack;
    assign busy      = r_busy;
    assign grant_id  = r_grant_id;
    assign ops_done  = r_ops_done;

endmodule
